// File: rtl/dma_host.sv
// dma_host: word-copy DMA engine with a register responder port and a bus host port.
// Define DMA_HOST_IRQ_EN to implement CTRL.IRQ_EN and drive dma_irq_o.
module dma_host #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_irq_o
);

  localparam int unsigned IdxWidth = 3;
  localparam logic [IdxWidth-1:0] RegSrc    = 3'd0;
  localparam logic [IdxWidth-1:0] RegDst    = 3'd1;
  localparam logic [IdxWidth-1:0] RegLen    = 3'd2;
  localparam logic [IdxWidth-1:0] RegCtrl   = 3'd3;
  localparam logic [IdxWidth-1:0] RegStatus = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [AddressWidth-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0]     len_q, len_d, rem_q, rem_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    host_req_q, host_req_d, host_we_q, host_we_d;
  logic [AddressWidth-1:0] host_addr_q, host_addr_d;
  logic [DataWidth-1:0]    host_wdata_q, host_wdata_d;
  logic                    dev_rvalid_q, dev_rvalid_d, dev_err_q, dev_err_d;
  logic [DataWidth-1:0]    dev_rdata_q, dev_rdata_d;
`ifdef DMA_HOST_IRQ_EN
  logic                    irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  logic                busy_c;
  logic                reg_wr_c;
  logic                start_c;
  logic [IdxWidth-1:0] reg_idx_c;
  logic                unused_ok;

  assign busy_c    = (state_q != S_IDLE);
  assign reg_idx_c = dev_addr_i[4:2];
  assign reg_wr_c  = dev_req_i && dev_we_i;
  assign start_c   = reg_wr_c && (reg_idx_c == RegCtrl) && dev_wdata_i[0] && !busy_c;
  // Byte enables and address bits outside the register index carry no meaning here.
  assign unused_ok = ^{dev_be_i, dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};

  // Register file, copy sequencer and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    rem_d        = rem_q;
    data_d       = data_q;
    done_d       = done_q;
    err_d        = err_q;
    host_req_d   = 1'b0;
    host_we_d    = 1'b0;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    dev_rvalid_d = dev_req_i;
    dev_err_d    = dev_req_i && (reg_idx_c > RegStatus);
    dev_rdata_d  = '0;
`ifdef DMA_HOST_IRQ_EN
    irq_en_d     = irq_en_q;
    irq_d        = 1'b0;
`endif

    if (dev_req_i && !dev_we_i) begin
      case (reg_idx_c)
        RegSrc:    dev_rdata_d = DataWidth'(src_q);
        RegDst:    dev_rdata_d = DataWidth'(dst_q);
        RegLen:    dev_rdata_d = DataWidth'(len_q);
`ifdef DMA_HOST_IRQ_EN
        RegCtrl:   dev_rdata_d = DataWidth'({irq_en_q, 1'b0});
`endif
        RegStatus: dev_rdata_d = DataWidth'({err_q, done_q, busy_c});
        default:   dev_rdata_d = '0;
      endcase
    end

    if (reg_wr_c && !busy_c) begin
      case (reg_idx_c)
        RegSrc:  src_d = dev_wdata_i[AddressWidth-1:0];
        RegDst:  dst_d = dev_wdata_i[AddressWidth-1:0];
        RegLen:  len_d = dev_wdata_i[LenWidth-1:0];
        default: ;
      endcase
    end
`ifdef DMA_HOST_IRQ_EN
    if (reg_wr_c && (reg_idx_c == RegCtrl)) irq_en_d = dev_wdata_i[1];
`endif
    if (reg_wr_c && (reg_idx_c == RegStatus)) begin
      if (dev_wdata_i[1]) done_d = 1'b0;
      if (dev_wdata_i[2]) err_d  = 1'b0;
    end

    // Hardware status sets come after the w1c clears so a same-cycle set wins.
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (len_q != '0) begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            rem_d     = len_q;
            state_d   = S_RD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD_REQ: if (host_gnt_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (host_rvalid_i) begin
          data_d = host_rdata_i;
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: if (host_gnt_i) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cur_src_d = cur_src_q + AddressWidth'(4);
            cur_dst_d = cur_dst_q + AddressWidth'(4);
            rem_d     = rem_q - LenWidth'(1);
            if (rem_d == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    host_req_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    host_we_d  = (state_d == S_WR_REQ);
    if (state_d == S_RD_REQ) begin
      host_addr_d = {cur_src_d[AddressWidth-1:2], 2'b00};
    end else if (state_d == S_WR_REQ) begin
      host_addr_d = {cur_dst_d[AddressWidth-1:2], 2'b00};
    end
    host_wdata_d = data_d;
`ifdef DMA_HOST_IRQ_EN
    irq_d = irq_en_d && (done_d || err_d);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      rem_q        <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      host_req_q   <= 1'b0;
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      dev_rvalid_q <= 1'b0;
      dev_err_q    <= 1'b0;
      dev_rdata_q  <= '0;
`ifdef DMA_HOST_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      host_req_q   <= host_req_d;
      host_we_q    <= host_we_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      dev_rvalid_q <= dev_rvalid_d;
      dev_err_q    <= dev_err_d;
      dev_rdata_q  <= dev_rdata_d;
`ifdef DMA_HOST_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;
  assign host_req_o   = host_req_q;
  assign host_we_o    = host_we_q;
  assign host_addr_o  = host_addr_q;
  assign host_wdata_o = host_wdata_q;
  assign host_be_o    = 4'hF;
`ifdef DMA_HOST_IRQ_EN
  assign dma_irq_o    = irq_q;
`else
  assign dma_irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dma_host.sv
// tb_dma_host: directed bench for dma_host with a small memory-backed bus responder.
module tb_dma_host;

  logic        clk_i;
  logic        rst_i;
  logic        dev_req_i, dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_addr_i, dev_wdata_i, dev_rdata_o;
  logic        dev_rvalid_o, dev_err_o;
  logic        host_req_o, host_gnt_i, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;
  logic        host_rvalid_i, host_err_i, dma_irq_o;

  dma_host dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .dma_irq_o(dma_irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_chk, n_pass;
  logic [31:0] mem [0:2047];
  int unsigned rd_cnt, wr_cnt, req_cycles, stall_cycles;
  int unsigned err_wr, err_rd, stall_rd, stall_n, hold, need;
  logic        cap_we, exp_we;
  logic [31:0] cap_addr, cap_wdata, hold_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bus responder: grant decided at negedge, response one cycle after the granting edge.
  always @(negedge clk_i) begin
    host_rvalid_i = 1'b0;
    host_err_i    = 1'b0;
    host_rdata_i  = '0;
    if (host_gnt_i) begin
      host_rvalid_i = 1'b1;
      if (cap_we) begin
        wr_cnt++;
        mem[cap_addr[12:2]] = cap_wdata;
        if (wr_cnt == err_wr) host_err_i = 1'b1;
      end else begin
        rd_cnt++;
        host_rdata_i = mem[cap_addr[12:2]];
        if (rd_cnt == err_rd) host_err_i = 1'b1;
      end
      chk("req_while_pending", {31'b0, host_req_o}, 32'd0);
    end
    host_gnt_i = 1'b0;
    if (host_req_o) begin
      req_cycles++;
      need = (!host_we_o && (rd_cnt + 1 == stall_rd)) ? stall_n : 0;
      if (hold != 0) begin
        chk("stall_addr", host_addr_o, hold_addr);
        chk("stall_we", {31'b0, host_we_o}, 32'd0);
        stall_cycles++;
      end else begin
        hold_addr = host_addr_o;
      end
      if (hold < need) begin
        hold++;
      end else begin
        host_gnt_i = 1'b1;
        cap_we     = host_we_o;
        cap_addr   = host_addr_o;
        cap_wdata  = host_wdata_o;
        hold       = 0;
        chk("rw_interleave", {31'b0, host_we_o}, {31'b0, exp_we});
        chk("host_be", {28'b0, host_be_o}, 32'h0000_000F);
        chk("addr_align", {30'b0, host_addr_o[1:0]}, 32'd0);
        exp_we = ~exp_we;
      end
    end
  end

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    dev_req_i = 1'b1; dev_we_i = 1'b1; dev_addr_i = a; dev_wdata_i = d;
    @(negedge clk_i);
    dev_req_i = 1'b0; dev_we_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(negedge clk_i);
    dev_req_i = 1'b1; dev_we_i = 1'b0; dev_addr_i = a;
    @(negedge clk_i);
    dev_req_i = 1'b0;
    chk("dev_rvalid", {31'b0, dev_rvalid_o}, 32'd1);
    d = dev_rdata_o;
    e = dev_err_o;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    reg_rd(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    logic        e;
    logic        idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      reg_rd(32'h10, d, e);
      if (!d[0]) idle = 1'b1;
    end
    chk("idle_reached", {31'b0, idle}, 32'd1);
  endtask

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; req_cycles = 0; stall_cycles = 0;
    err_wr = 0; err_rd = 0; stall_rd = 0; stall_n = 0; hold = 0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        seen;
    n_chk = 0; n_pass = 0;
    rst_i = 1'b1; dev_req_i = 1'b0; dev_we_i = 1'b0; dev_be_i = 4'hF;
    dev_addr_i = '0; dev_wdata_i = '0;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; hold_addr = '0; exp_we = 1'b0; need = 0;
    clr();
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[0]  = 32'h1111_0001; mem[1]  = 32'h2222_0002;
    mem[2]  = 32'h3333_0003; mem[3]  = 32'h4444_0004;
    mem[16] = 32'hDEAD_0010; mem[17] = 32'hBEEF_0011; mem[18] = 32'hCAFE_0012;

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_req", {31'b0, host_req_o}, 32'd0);
    chk("rst_we", {31'b0, host_we_o}, 32'd0);
    chk("rst_addr", host_addr_o, 32'd0);
    chk("rst_wdata", host_wdata_o, 32'd0);
    chk("rst_rvalid", {31'b0, dev_rvalid_o}, 32'd0);
    chk("rst_rdata", dev_rdata_o, 32'd0);
    chk("rst_deverr", {31'b0, dev_err_o}, 32'd0);
    chk("rst_irq", {31'b0, dma_irq_o}, 32'd0);
    rst_i = 1'b0;
    reg_rd(32'h10, d, e);
    chk("rst_status", d, 32'd0);
    chk("status_deverr", {31'b0, e}, 32'd0);

    // Basic 4-word copy
    reg_wr(32'h00, 32'h0010_0000);
    reg_wr(32'h04, 32'h0010_0400);
    reg_wr(32'h08, 32'd4);
    reg_wr(32'h0C, 32'h1);
    wait_idle();
    chk("cp_w0", mem[256], 32'h1111_0001);
    chk("cp_w1", mem[257], 32'h2222_0002);
    chk("cp_w2", mem[258], 32'h3333_0003);
    chk("cp_w3", mem[259], 32'h4444_0004);
    chk("cp_reads", rd_cnt, 32'd4);
    chk("cp_writes", wr_cnt, 32'd4);
    chk("cp_req_cycles", req_cycles, 32'd8);
    rd_chk("cp_status", 32'h10, 32'h2);
    rd_chk("cp_src_rb", 32'h00, 32'h0010_0000);
    rd_chk("cp_dst_rb", 32'h04, 32'h0010_0400);
    rd_chk("cp_len_rb", 32'h08, 32'd4);
    rd_chk("ctrl_start_rd0", 32'h0C, 32'd0);

    // LEN=0: DONE with no bus traffic
    reg_wr(32'h10, 32'h6);
    clr();
    reg_wr(32'h08, 32'd0);
    reg_wr(32'h0C, 32'h1);
    rd_chk("len0_status", 32'h10, 32'h2);
    repeat (5) @(negedge clk_i);
    chk("len0_no_req", req_cycles, 32'd0);

    // Delayed grant on the 2nd read, misaligned SRC
    reg_wr(32'h10, 32'h6);
    clr();
    stall_rd = 2; stall_n = 3;
    reg_wr(32'h00, 32'h0010_0042);
    reg_wr(32'h04, 32'h0010_0500);
    reg_wr(32'h08, 32'd3);
    reg_wr(32'h0C, 32'h1);
    wait_idle();
    chk("stall_cycles", stall_cycles, 32'd3);
    chk("stall_w0", mem[320], 32'hDEAD_0010);
    chk("stall_w1", mem[321], 32'hBEEF_0011);
    chk("stall_w2", mem[322], 32'hCAFE_0012);
    rd_chk("stall_src_rb", 32'h00, 32'h0010_0042);
    rd_chk("stall_status", 32'h10, 32'h2);

    // Bus error on the 2nd write of LEN=3, with IRQ_EN set
    reg_wr(32'h10, 32'h6);
    clr();
    err_wr = 2;
    reg_wr(32'h00, 32'h0010_0000);
    reg_wr(32'h04, 32'h0010_0600);
    reg_wr(32'h08, 32'd3);
    reg_wr(32'h0C, 32'h3);
    wait_idle();
    repeat (10) @(negedge clk_i);
    chk("err_writes", wr_cnt, 32'd2);
    chk("err_reads", rd_cnt, 32'd2);
    chk("err_req_cycles", req_cycles, 32'd4);
    rd_chk("err_status", 32'h10, 32'h4);
`ifdef DMA_HOST_IRQ_EN
    rd_chk("ctrl_irq_en_rb", 32'h0C, 32'h2);
    chk("irq_set", {31'b0, dma_irq_o}, 32'd1);
`else
    rd_chk("ctrl_irq_en_rb", 32'h0C, 32'h0);
    chk("irq_tied", {31'b0, dma_irq_o}, 32'd0);
`endif
    reg_wr(32'h10, 32'h4);
    @(negedge clk_i);
    chk("irq_clr", {31'b0, dma_irq_o}, 32'd0);
    rd_chk("err_status_clr", 32'h10, 32'h0);
    reg_wr(32'h0C, 32'h0);

    // Writes to LEN and START while busy are ignored
    clr();
    reg_wr(32'h00, 32'h0010_0000);
    reg_wr(32'h04, 32'h0010_0700);
    reg_wr(32'h08, 32'd2);
    reg_wr(32'h0C, 32'h1);
    reg_wr(32'h08, 32'd9);
    reg_wr(32'h0C, 32'h1);
    wait_idle();
    repeat (10) @(negedge clk_i);
    rd_chk("busy_len_rb", 32'h08, 32'd2);
    chk("busy_reads", rd_cnt, 32'd2);
    chk("busy_writes", wr_cnt, 32'd2);
    chk("busy_w0", mem[448], 32'h1111_0001);
    chk("busy_w1", mem[449], 32'h2222_0002);
    rd_chk("busy_status", 32'h10, 32'h2);

    // Reset while a write response is pending
    reg_wr(32'h10, 32'h6);
    clr();
    reg_wr(32'h04, 32'h0010_0800);
    reg_wr(32'h08, 32'd4);
    reg_wr(32'h0C, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (host_req_o && host_we_o) seen = 1'b1;
    end
    chk("wr_req_seen", {31'b0, seen}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_rst_req", {31'b0, host_req_o}, 32'd0);
    chk("mid_rst_addr", host_addr_o, 32'd0);
    chk("mid_rst_wdata", host_wdata_o, 32'd0);
    rd_chk("mid_rst_status", 32'h10, 32'd0);
    rd_chk("mid_rst_len", 32'h08, 32'd0);
    reg_rd(32'h18, d, e);
    chk("unmapped_err", {31'b0, e}, 32'd1);
    chk("unmapped_rdata", d, 32'd0);
    repeat (5) @(negedge clk_i);
    chk("post_rst_no_req", {31'b0, host_req_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
